// File: rtl/eros_arb_pkg.sv
// Shared types for the EROS OBI round-robin arbiter: lock FSM states, default
// OBI payload structs and the master-index width helper.
package eros_arb_pkg;

   localparam int unsigned OBI_ADDR_W = 32;
   localparam int unsigned OBI_DATA_W = 32;
   localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                  req;
      logic                  we;
      logic [OBI_BE_W-1:0]   be;
      logic [OBI_ADDR_W-1:0] addr;
      logic [OBI_DATA_W-1:0] wdata;
   } eros_obi_req_t;

   typedef struct packed {
      logic                  gnt;
      logic                  rvalid;
      logic [OBI_DATA_W-1:0] rdata;
   } eros_obi_resp_t;

   // Width of a master index; never zero so single-bit indices stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/eros_idx_fifo.sv
// Synchronous FIFO of master indices for granted, not-yet-answered transactions.
// Registered full/empty/count, no fall-through; push+pop while full is accepted.
module eros_idx_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop_i && (r_count != '0);
   assign w_push = push_i && ((r_count != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= push_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
         if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   assign head_o  = r_mem[r_rptr];
   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;

endmodule

// File: rtl/eros_obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter with request lock until grant and an index
// FIFO that steers each rvalid/rdata back to the master that issued it.
import eros_arb_pkg::*;

module eros_obi_rr_arbiter #(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter type         obi_req_t       = eros_arb_pkg::eros_obi_req_t,
   parameter type         obi_resp_t      = eros_arb_pkg::eros_obi_resp_t
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  obi_req_t                               master_req_i  [NUM_MASTERS],
   output obi_resp_t                              master_resp_o [NUM_MASTERS],
   output obi_req_t                               slave_req_o,
   input  obi_resp_t                              slave_resp_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   err_o
);

   localparam int unsigned IW = idx_width(NUM_MASTERS);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   arb_state_e    r_state;
   logic [IW-1:0] r_rr;
   logic [IW-1:0] r_lock_idx;
   logic          r_err;

   logic [IW-1:0] w_rr_idx;
   logic [IW-1:0] w_cand;
   logic [IW-1:0] w_winner;
   logic [IW-1:0] w_head;
   logic [CW-1:0] w_count;
   logic          w_found;
   logic          w_valid;
   logic          w_fwd;
   logic          w_hs;
   logic          w_drop;
   logic          w_pop;
   logic          w_stray;
   logic          w_full;
   logic          w_empty;

   // First requester at or after the round-robin pointer, wrapping to 0.
   always_comb begin
      w_found  = 1'b0;
      w_rr_idx = '0;
      w_cand   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_cand = IW'((32'(r_rr) + 32'(i)) % NUM_MASTERS);
         if (!w_found && master_req_i[w_cand].req) begin
            w_found  = 1'b1;
            w_rr_idx = w_cand;
         end
      end
   end

   // Full gate uses the registered occupancy, so a pop never frees a slot in the same cycle.
   always_comb begin
      w_winner = (r_state == LOCK) ? r_lock_idx : w_rr_idx;
      w_valid  = (r_state == LOCK) ? master_req_i[r_lock_idx].req : w_found;
      w_drop   = (r_state == LOCK) && !master_req_i[r_lock_idx].req && !rst_i;
      w_fwd    = w_valid && !w_full && !rst_i;
      w_hs     = w_fwd && slave_resp_i.gnt;
      w_pop    = slave_resp_i.rvalid && !w_empty && !rst_i;
      w_stray  = slave_resp_i.rvalid && w_empty && !rst_i;
   end

   always_comb begin
      slave_req_o = '0;
      if (w_valid) begin
         slave_req_o     = master_req_i[w_winner];
         slave_req_o.req = w_fwd;
      end
   end

   always_comb begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
         master_resp_o[m]        = '0;
         master_resp_o[m].rdata  = slave_resp_i.rdata;
         master_resp_o[m].gnt    = w_fwd && slave_resp_i.gnt && (w_winner == IW'(m));
         master_resp_o[m].rvalid = w_pop && (w_head == IW'(m));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ARB;
         r_rr       <= '0;
         r_lock_idx <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_hs) r_rr <= IW'((32'(w_winner) + 32'd1) % NUM_MASTERS);
         if (w_drop || w_stray) r_err <= 1'b1;
         case (r_state)
            ARB: begin
               if (w_fwd && !slave_resp_i.gnt) begin
                  r_state    <= LOCK;
                  r_lock_idx <= w_winner;
               end
            end
            LOCK: begin
               if (w_hs || w_drop) r_state <= ARB;
            end
            default: r_state <= ARB;
         endcase
      end
   end

   eros_idx_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IW)
   ) u_idx_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_hs),
      .push_data_i (w_winner),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .count_o     (w_count)
   );

   assign outstanding_o = w_count;
   assign err_o         = r_err;

endmodule
